// File: rtl/instr_mem_ctrl.sv
// Runtime-loadable instruction memory for the IF stage: zero-fill on boot,
// program load over a write port, then registered fetch with freeze/flush.
module instr_mem_ctrl #(
   parameter int          DEPTH     = 64,
   parameter int          AW        = 32,
   parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data,
   input  logic          ld_done,
   input  logic          fetch_req,
   input  logic [AW-1:0] PC,
   input  logic          freeze,
   input  logic          flush,
   output logic          ready,
   output logic [31:0]   Instruction,
   output logic          instr_valid,
   output logic          fault
);

   localparam int            IW         = $clog2(DEPTH);
   localparam logic [AW-1:0] BYTE_LIMIT = AW'(DEPTH * 4);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_LOAD,
      S_RUN
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;

   logic [31:0]   mem [DEPTH];
   logic          mem_we;
   logic [IW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   logic [31:0]   instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          fault_q, fault_d;

   logic [IW-1:0] pc_idx;
   logic [IW-1:0] ld_idx;
   logic          pc_bad;
   logic          ld_in_range;

   assign pc_idx      = PC[IW+1:2];
   assign ld_idx      = ld_addr[IW+1:2];
   assign pc_bad      = (PC >= BYTE_LIMIT) || (PC[1:0] != 2'b00);
   assign ld_in_range = (ld_addr < BYTE_LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == IW'(DEPTH - 1)) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (ld_done) state_d = S_RUN;
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_CLEAR;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = FILL_WORD;
      case (state_q)
         S_CLEAR: mem_we = 1'b1;
         S_LOAD: begin
            mem_we    = ld_en && ld_in_range;
            mem_waddr = ld_idx;
            mem_wdata = ld_data;
         end
         S_RUN:   ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // NOTE: the array has no reset; the CLEAR sweep initialises it so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Flush beats freeze; freeze holds all three fetch outputs.
   always_comb begin
      instr_d = instr_q;
      valid_d = valid_q;
      fault_d = fault_q;
      if (state_q != S_RUN || flush) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
      end else if (!freeze) begin
         if (fetch_req) begin
            valid_d = 1'b1;
            fault_d = pc_bad;
            instr_d = pc_bad ? FILL_WORD : mem[pc_idx];
         end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q <= FILL_WORD;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign Instruction = instr_q;
   assign instr_valid = valid_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: boot timing, load, vector-table fetches,
// freeze/flush corners and reset during RUN and LOAD.
module tb_instr_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_done;
   logic        fetch_req;
   logic [31:0] PC;
   logic        freeze;
   logic        flush;
   logic        ready;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic        fault;

   int n_cmp = 0;
   int n_err = 0;

   instr_mem_ctrl #(
      .DEPTH    (64),
      .AW       (32),
      .FILL_WORD(32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_done    (ld_done),
      .fetch_req  (fetch_req),
      .PC         (PC),
      .freeze     (freeze),
      .flush      (flush),
      .ready      (ready),
      .Instruction(Instruction),
      .instr_valid(instr_valid),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic        frz;
      logic        fls;
      logic        chk_instr;
      logic [31:0] instr;
      logic        valid;
      logic        flt;
   } vec_t;

   vec_t vecs [17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      fetch_req = 1'b1;
      PC        = addr;
      tick();
      fetch_req = 1'b0;
      check({name, ".instr"}, Instruction, exp);
      check({name, ".valid"}, {31'd0, instr_valid}, 32'd1);
      check({name, ".fault"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      // Program after the main load: [0]=E3A00014 [1]=E3A01A01 [2]=AABBCCDD [63]=12345678, rest 0.
      vecs[0]  = '{1'b1, 32'h000, 1'b0, 1'b0, 1'b1, 32'hE3A0_0014, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 32'h004, 1'b0, 1'b0, 1'b1, 32'hE3A0_1A01, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 32'h008, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 32'h0FC, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 32'h006, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 32'h000, 1'b0, 1'b0, 1'b1, 32'hE3A0_0014, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 32'h004, 1'b1, 1'b0, 1'b1, 32'hE3A0_0014, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 32'hE3A0_0014, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 32'hE3A0_0014, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 32'h004, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 32'h004, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 32'h00C, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

      rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
      fetch_req = 1'b0; PC = '0; freeze = 1'b0; flush = 1'b0;
      repeat (2) tick();
      check("reset.ready", {31'd0, ready}, 32'd0);
      check("reset.valid", {31'd0, instr_valid}, 32'd0);
      check("reset.fault", {31'd0, fault}, 32'd0);
      check("reset.instr", Instruction, 32'h0000_0000);

      // Boot with ld_done held: CLEAR must last exactly 64 edges, then one LOAD edge.
      ld_done = 1'b1;
      rst     = 1'b1;
      repeat (64) tick();
      check("boot.ready_after_64", {31'd0, ready}, 32'd0);
      tick();
      check("boot.ready_after_65", {31'd0, ready}, 32'd1);
      ld_done = 1'b0;
      fetch_check("boot.fetch10", 32'h10, 32'h0000_0000);
      fetch_check("boot.fetchFC", 32'hFC, 32'h0000_0000);

      // Asynchronous reset while a valid fetch is showing.
      rst = 1'b0;
      #1;
      check("rst_run.ready", {31'd0, ready}, 32'd0);
      check("rst_run.valid", {31'd0, instr_valid}, 32'd0);
      tick();
      rst = 1'b1;
      repeat (64) tick();
      check("load.ready_low", {31'd0, ready}, 32'd0);
      load(32'h000, 32'hE3A0_0014);
      load(32'h004, 32'hE3A0_1A01);
      load(32'h100, 32'hDEAD_BEEF);
      load(32'h0FF, 32'h1234_5678);
      load(32'h00B, 32'hAABB_CCDD);
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      check("load.ready_high", {31'd0, ready}, 32'd1);
      load(32'h000, 32'hBADB_AD00);

      for (int i = 0; i < 17; i++) begin
         fetch_req = vecs[i].req;
         PC        = vecs[i].pc;
         freeze    = vecs[i].frz;
         flush     = vecs[i].fls;
         tick();
         if (vecs[i].chk_instr) check($sformatf("vec%0d.instr", i), Instruction, vecs[i].instr);
         check($sformatf("vec%0d.valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].valid});
         check($sformatf("vec%0d.fault", i), {31'd0, fault}, {31'd0, vecs[i].flt});
      end
      fetch_req = 1'b0; freeze = 1'b0; flush = 1'b0;

      // Reset in the middle of a four-word load; the partial program must not survive.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (64) tick();
      load(32'h000, 32'h1111_1111);
      load(32'h004, 32'h2222_2222);
      ld_en   = 1'b1;
      ld_addr = 32'h008;
      ld_data = 32'h3333_3333;
      rst     = 1'b0;
      #1;
      check("rst_load.ready", {31'd0, ready}, 32'd0);
      check("rst_load.valid", {31'd0, instr_valid}, 32'd0);
      ld_en = 1'b0;
      tick();
      ld_done = 1'b1;
      rst     = 1'b1;
      repeat (65) tick();
      ld_done = 1'b0;
      check("reboot.ready", {31'd0, ready}, 32'd1);
      fetch_check("reboot.fetch0", 32'h0, 32'h0000_0000);
      fetch_check("reboot.fetch4", 32'h4, 32'h0000_0000);

      // ld_en and ld_done together: the write lands before RUN.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (64) tick();
      ld_en   = 1'b1;
      ld_addr = 32'h008;
      ld_data = 32'hE084_3002;
      ld_done = 1'b1;
      tick();
      ld_en   = 1'b0;
      ld_done = 1'b0;
      check("same_cycle.ready", {31'd0, ready}, 32'd1);
      fetch_check("same_cycle.fetch8", 32'h8, 32'hE084_3002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
